hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage processor.
- Drives the enable and bubble inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC enable.
- Sequences stalls for load-use hazards, multicycle multiply ops in E and data-cache misses in M.
- Also produces the E-stage forwarding selects and the taken-branch F/D flush.

Parameters:
MUL_LAT, 4, cycles a multiply occupies E (≥1; 1 = no stall)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rsD  in  5  D-stage source reg A
rtD  in  5  D-stage source reg B
rsE  in  5  E-stage source reg A
rtE  in  5  E-stage source reg B
WriteRegE  in  5  E-stage destination
RegWriteE  in  1  E-stage writes register
MemToRegE  in  1  E-stage is a load
mulE  in  1  E-stage holds multicycle multiply
WriteRegM  in  5  M-stage destination
RegWriteM  in  1  M-stage writes register
dmissM  in  1  M-stage data-cache miss
dreadyM  in  1  cache fill complete
WriteRegW  in  5  W-stage destination
RegWriteW  in  1  W-stage writes register
takenD  in  1  branch resolved taken in D
enPC  out  1  PC enable
enFD  out  1  F/D register enable
enDE  out  1  D/E register enable
enEM  out  1  E/M register enable
enMW  out  1  M/W register enable
nopDE  out  1  D/E loads bubble (all zero)
flushFD  out  1  F/D loads bubble
forwardAE  out  2  SrcA select: 00 regfile, 01 W, 10 M
forwardBE  out  2  SrcB select, same encoding
busy  out  1  state != RUN

Behaviour:
- State: RUN, MEM_WAIT, MUL_WAIT. Counter cnt of width clog2(MUL_LAT)+1.
- Reset: state=RUN, cnt=0. While reset is high, all en*=0, nopDE=0, flushFD=0, forward*=00, busy=0.
- Forwarding (combinational, every state), for A:
  - 10 if RegWriteM & WriteRegM!=0 & WriteRegM==rsE;
  - else 01 if RegWriteW & WriteRegW!=0 & WriteRegW==rsE;
  - else 00.
  - B is identical using rtE.
- Load-use (lu) = MemToRegE & RegWriteE & WriteRegE!=0 & (WriteRegE==rsD | WriteRegE==rtD).
- RUN, priority highest first:
  - dmissM: all en*=0, nopDE=0, flushFD=0; next state MEM_WAIT.
  - else mulE & MUL_LAT>1: all en*=0; cnt<=MUL_LAT-2; next state MUL_WAIT.
  - else lu: enPC=enFD=0, enDE=enEM=enMW=1, nopDE=1, flushFD=0. This is a single-cycle bubble with no state change.
  - else: all en*=1, nopDE=0, flushFD=takenD.
- MEM_WAIT:
  - All en*=0 while !dreadyM.
  - In the dreadyM cycle: all en*=1, nopDE=0, flushFD=0; next state RUN.
  - lu and mulE are not evaluated in this state.
  - A mulE still present after return is handled in RUN.
- MUL_WAIT:
  - All en*=0 while cnt!=0; cnt decrements each cycle.
  - When cnt==0: all en*=1, nopDE=0, flushFD=0; next state RUN.
  - dmissM is ignored (M is frozen, so no new miss can arise).
  - Total stall = MUL_LAT-1 cycles.
- Simultaneous dmissM & mulE: MEM_WAIT first, then the MUL stall on return.
- Simultaneous takenD & lu: lu wins, flushFD=0; the branch re-resolves next cycle.
- Reset mid-stall: state returns to RUN immediately and asynchronously.
- All outputs are combinational from state, cnt and inputs; no added latency.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN=0, MEM_WAIT=1, MUL_WAIT=2);
  - forward constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- Sub-module fwd_unit: purely combinational forwarding, instantiated once per source operand (A and B).

Test Plan:
1. Load-use: MemToRegE=1, RegWriteE=1, WriteRegE=8, rsD=8 → enPC=enFD=0, enDE=1, nopDE=1 for exactly one cycle. Same case with WriteRegE=0 → no stall.
2. Multiply, MUL_LAT=4: mulE=1 held → en*=0 in cycles 0–2, en*=1 in cycle 3, busy=1 in cycles 1–3. With MUL_LAT=1 → no stall.
3. Cache miss: dmissM=1 at cycle 0, dreadyM=1 at cycle 5 → en*=0 in cycles 0–4, en*=1 in cycle 5, state RUN in cycle 6.
4. Forwarding: RegWriteM=RegWriteW=1, WriteRegM=WriteRegW=5, rsE=5 → forwardAE=10. WriteRegM=0 → forwardAE=01. rtE=0 → forwardBE=00.
5. Simultaneous dmissM & mulE (MUL_LAT=4), dreadyM at cycle 2 → MEM_WAIT cycles 0–2, then a 3-cycle MUL stall; takenD & lu together → flushFD=0, nopDE=1.
6. Reset asserted during MUL_WAIT with cnt=1 → busy=0 and en*=0 immediately; after release, state RUN with en*=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline status in, stage enables / bubbles / forwarding selects out.
interface hazard_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] WriteRegE;
  logic       RegWriteE;
  logic       MemToRegE;
  logic       mulE;
  logic [4:0] WriteRegM;
  logic       RegWriteM;
  logic       dmissM;
  logic       dreadyM;
  logic [4:0] WriteRegW;
  logic       RegWriteW;
  logic       takenD;
  logic       enPC;
  logic       enFD;
  logic       enDE;
  logic       enEM;
  logic       enMW;
  logic       nopDE;
  logic       flushFD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       busy;

  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, RegWriteE, MemToRegE, mulE,
           WriteRegM, RegWriteM, dmissM, dreadyM, WriteRegW, RegWriteW, takenD,
    input  enPC, enFD, enDE, enEM, enMW, nopDE, flushFD, forwardAE, forwardBE, busy
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, RegWriteE, MemToRegE, mulE,
           WriteRegM, RegWriteM, dmissM, dreadyM, WriteRegW, RegWriteW, takenD,
    output enPC, enFD, enDE, enEM, enMW, nopDE, flushFD, forwardAE, forwardBE, busy
  );
endinterface

// File: rtl/fwd_unit.sv
// E-stage operand bypass select; M result takes precedence over W as it is newer.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src_e,
  input  logic [4:0] wr_reg_m,
  input  logic       reg_write_m,
  input  logic [4:0] wr_reg_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (wr_reg_m != 5'd0) && (wr_reg_m == src_e))
      fwd_sel = FWD_M;
    else if (reg_write_w && (wr_reg_w != 5'd0) && (wr_reg_w == src_e))
      fwd_sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// multicycle multiply holds and data-cache miss holds, plus E-stage forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_front, en_back, nop_de, flush_fd, lu;
  logic [1:0]    fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .src_e       (hz.rsE),
    .wr_reg_m    (hz.WriteRegM),
    .reg_write_m (hz.RegWriteM),
    .wr_reg_w    (hz.WriteRegW),
    .reg_write_w (hz.RegWriteW),
    .fwd_sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .src_e       (hz.rtE),
    .wr_reg_m    (hz.WriteRegM),
    .reg_write_m (hz.RegWriteM),
    .wr_reg_w    (hz.WriteRegW),
    .reg_write_w (hz.RegWriteW),
    .fwd_sel     (fwd_b)
  );

  assign lu = hz.MemToRegE && hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
              ((hz.WriteRegE == hz.rsD) || (hz.WriteRegE == hz.rtD));

  // en_front gates PC and F/D; en_back gates D/E, E/M and M/W.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_front = 1'b0;
    en_back  = 1'b0;
    nop_de   = 1'b0;
    flush_fd = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.dmissM) begin
          state_d = MEM_WAIT;
        end else if (hz.mulE && (MUL_LAT > 1)) begin
          cnt_d   = CNT_INIT;
          state_d = MUL_WAIT;
        end else if (lu) begin
          en_back = 1'b1;
          nop_de  = 1'b1;
        end else begin
          en_front = 1'b1;
          en_back  = 1'b1;
          flush_fd = hz.takenD;
        end
      end
      MEM_WAIT: begin
        if (hz.dreadyM) begin
          en_front = 1'b1;
          en_back  = 1'b1;
          state_d  = RUN;
        end
      end
      MUL_WAIT: begin
        if (cnt_q == '0) begin
          en_front = 1'b1;
          en_back  = 1'b1;
          state_d  = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything is forced quiet while reset is held, forwarding included.
  assign hz.enPC      = en_front & ~reset;
  assign hz.enFD      = en_front & ~reset;
  assign hz.enDE      = en_back & ~reset;
  assign hz.enEM      = en_back & ~reset;
  assign hz.enMW      = en_back & ~reset;
  assign hz.nopDE     = nop_de & ~reset;
  assign hz.flushFD   = flush_fd & ~reset;
  assign hz.forwardAE = reset ? FWD_RF : fwd_a;
  assign hz.forwardBE = reset ? FWD_RF : fwd_b;
  assign hz.busy      = (state_q != RUN) & ~reset;

endmodule
